tmds_channel_decoder: RTL



---
 rtl/hdmi_pkg.sv | 66 ++++++
 rtl/tmds_word_aligner.sv | 92 +++++++++
 rtl/tmds_channel_decoder.sv | 60 ++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI/TMDS constants, token table and symbol helpers.
// Used by both the TMDS encoder and the channel decoder.
package hdmi_pkg;

  localparam int TMDS_W = 10;

  localparam logic [TMDS_W-1:0] TOK_C00 = 10'h354;
  localparam logic [TMDS_W-1:0] TOK_C01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] TOK_C10 = 10'h154;
  localparam logic [TMDS_W-1:0] TOK_C11 = 10'h2AB;

  // Indexed by {c1,c0}
  localparam logic [TMDS_W-1:0] CTRL_TOKEN [4] = '{
    TOK_C00, TOK_C01, TOK_C10, TOK_C11
  };

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;

  typedef enum logic {
    AL_SEARCH,
    AL_LOCKED
  } align_state_t;

  function automatic logic is_token(
    input logic [TMDS_W-1:0] w
  );
    return (w == TOK_C00) || (w == TOK_C01) ||
           (w == TOK_C10) || (w == TOK_C11);
  endfunction

  function automatic logic [1:0] token_ctrl(
    input logic [TMDS_W-1:0] w
  );
    logic [1:0] c;
    case (w)
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] tmds_decode(
    input logic [TMDS_W-1:0] q
  );
    logic [7:0] d;
    logic [7:0] o;
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Finds the TMDS symbol boundary in an unaligned 10-bit word stream
// by hunting for runs of control tokens, one bit offset at a time.
module tmds_word_aligner
  import hdmi_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic              pixclk,
  input  logic              rst_n,
  input  logic [TMDS_W-1:0] i_raw,
  output logic [TMDS_W-1:0] o_aligned,
  output logic              o_locked,
  output logic [3:0]        o_offset
);

  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TMAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ?
                        SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int TW = $clog2(TMAX);
  localparam logic [RW-1:0] RUN_MAX = RW'(CTRL_RUN);
  localparam logic [TW-1:0] S_TC = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] L_TC = TW'(LOSS_TIMEOUT - 1);

  logic [TMDS_W-1:0]   r_prev;
  logic [TMDS_W-1:0]   r_aligned;
  logic [RW-1:0]       r_run;
  logic [TW-1:0]       r_tmo;
  logic [3:0]          r_off;
  align_state_t        r_state;

  logic [2*TMDS_W-1:0] w_win;
  logic                w_tok;
  logic [RW-1:0]       w_run_nxt;
  logic                w_hit;

  assign w_win = {i_raw, r_prev};
  assign w_tok = is_token(r_aligned);

  always_comb begin
    w_run_nxt = '0;
    if (w_tok) begin
      w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
    end
  end

  // A completed run beats a same-cycle timeout.
  assign w_hit = (w_run_nxt == RUN_MAX);

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= '0;
      r_aligned <= '0;
      r_run     <= '0;
      r_tmo     <= '0;
      r_off     <= '0;
      r_state   <= AL_SEARCH;
    end else begin
      r_prev    <= i_raw;
      r_aligned <= w_win[r_off +: TMDS_W];
      r_run     <= w_run_nxt;
      r_tmo     <= r_tmo + 1'b1;
      unique case (r_state)
        AL_SEARCH: begin
          if (w_hit) begin
            r_state <= AL_LOCKED;
            r_tmo   <= '0;
          end else if (r_tmo == S_TC) begin
            r_off <= (r_off == 4'd9) ? 4'd0 : r_off + 4'd1;
            r_run <= '0;
            r_tmo <= '0;
          end
        end
        AL_LOCKED: begin
          if (w_hit) begin
            r_tmo <= '0;
          end else if (r_tmo == L_TC) begin
            r_state <= AL_SEARCH;
            r_run   <= '0;
            r_tmo   <= '0;
          end
        end
      endcase
    end
  end

  assign o_aligned = r_aligned;
  assign o_locked  = (r_state == AL_LOCKED);
  assign o_offset  = r_off;

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment followed by a
// registered 10b->8b decode with DE and control recovery.
module tmds_channel_decoder
  import hdmi_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic              pixclk,
  input  logic              rst_n,
  input  logic [TMDS_W-1:0] raw_word,
  output logic [7:0]        data,
  output logic              de,
  output logic [1:0]        ctrl,
  output logic              locked,
  output logic [3:0]        bit_offset
);

  logic [TMDS_W-1:0] w_aligned;
  logic              w_tok;
  logic [7:0]        r_data;
  logic              r_de;
  logic [1:0]        r_ctrl;

  tmds_word_aligner #(
    .CTRL_RUN       (CTRL_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) u_align (
    .pixclk    (pixclk),
    .rst_n     (rst_n),
    .i_raw     (raw_word),
    .o_aligned (w_aligned),
    .o_locked  (locked),
    .o_offset  (bit_offset)
  );

  assign w_tok = is_token(w_aligned);

  // ctrl holds the last token's value through data periods
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_de   <= 1'b0;
      r_ctrl <= '0;
    end else begin
      r_de   <= !w_tok;
      r_data <= w_tok ? 8'h00 : tmds_decode(w_aligned);
      if (w_tok) begin
        r_ctrl <= token_ctrl(w_aligned);
      end
    end
  end

  assign data = r_data;
  assign de   = r_de;
  assign ctrl = r_ctrl;

endmodule
